pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width in bits.
REQ-002 Parameter SEG_WIDTH, default 8, bits resolved per pipeline stage; NUM_SEG = DATA_WIDTH/SEG_WIDTH stages.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operands and op presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  DATA_WIDTH  operand A, unsigned or two's complement.
REQ-008 Port b  input  DATA_WIDTH  operand B.
REQ-009 Port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-010 Port out_valid  output  1  result available.
REQ-011 Port out_ready  input  1  consumer takes result this cycle.
REQ-012 Port sum  output  DATA_WIDTH+1  result; sum[DATA_WIDTH] is carry-out; for subtract, 1 = no borrow.

Function
REQ-013 Transfer on a port occurs when valid and ready are both high at a rising clk edge.
REQ-014 Subtract SHALL be computed as a + ~b + 1: segment 0 carry-in = op, b inverted when op = 1.
REQ-015 Stage k adds bits [k*SEG_WIDTH +: SEG_WIDTH] using the carry registered by stage k-1; stage 0 uses carry-in per REQ-014.
REQ-016 Operand bits not yet consumed and result bits already produced travel with their stage, together with the op bit and a per-stage valid flag.
REQ-017 Latency SHALL be exactly NUM_SEG cycles from input transfer to out_valid with no backpressure; throughput one result per cycle.
REQ-018 Stage k loads when its valid is low or stage k+1 loads (final stage: out_ready high); in_ready = stage-0 load condition, combinational from out_ready.
REQ-019 Bubbles SHALL collapse: an empty stage accepts data even while downstream is stalled.
REQ-020 A stalled stage holds its contents unchanged; no result is dropped, duplicated or reordered.
REQ-021 Full condition: all NUM_SEG stages valid and out_ready low -> in_ready low.
REQ-022 Simultaneous input and output transfer on a full pipe is legal and keeps occupancy at NUM_SEG.
REQ-023 sum and out_valid SHALL be driven only by final-stage registers (no combinational input-to-output path).
REQ-024 SEG_WIDTH = DATA_WIDTH yields a single stage, latency 1.
REQ-025 DATA_WIDTH not a multiple of SEG_WIDTH, or SEG_WIDTH < 1, SHALL cause an elaboration error.

Reset
REQ-026 rst_n low SHALL immediately clear every stage valid flag, so out_valid = 0 and in_ready = 1 while reset is held.
REQ-027 All data, carry and op registers SHALL reset to 0; sum = 0 in reset.
REQ-028 Transactions in flight at reset are discarded; no result for them appears after release.

Configuration
REQ-029 Macro PIPELINED_ADDER_OVF_EN defined: output port ovf (1 bit) carries signed two's-complement overflow for the final result, aligned with out_valid, reset 0.
REQ-030 PIPELINED_ADDER_OVF_EN undefined: port ovf and its logic are absent; all other behaviour identical.

Structure
REQ-031 Package pipelined_adder_pkg holds the op encoding typedef (OP_ADD = 0, OP_SUB = 1) and a function computing NUM_SEG from the widths.
REQ-032 Combinational sub-module adder_segment (SEG_WIDTH-bit ripple adder with cin and cout) is instantiated once per stage.

Verification (DATA_WIDTH = 32, SEG_WIDTH = 8)
REQ-033 Add a = 0xFFFFFFFF, b = 0x1, out_ready = 1 -> out_valid after exactly 4 cycles, sum = 0x1_00000000.
REQ-034 Subtract a = 5, b = 7 -> sum = 0x0_FFFFFFFE; subtract a = 7, b = 5 -> sum = 0x1_00000002.
REQ-035 Eight back-to-back mixed ops, out_ready low for 6 cycles mid-stream -> in_ready low once 4 are held, all 8 results in order with no loss or duplication.
REQ-036 rst_n pulsed low with 3 transactions in flight -> out_valid 0 immediately and no result for those 3 after release; next input completes in 4 cycles.
REQ-037 With PIPELINED_ADDER_OVF_EN: 0x7FFFFFFF + 1 -> ovf = 1; 0x80000000 - 1 -> ovf = 1; 3 + 4 -> ovf = 0.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: the op encoding and
// the stage-count helper used to size and validate the pipeline.
package pipelined_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Returns 0 for any illegal width combination so the top can reject it.
   function automatic int calc_num_seg(input int data_width, input int seg_width);
      if (seg_width < 1) return 0;
      if (data_width < seg_width) return 0;
      if ((data_width % seg_width) != 0) return 0;
      return data_width / seg_width;
   endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// adder_segment: combinational SEG_WIDTH-bit ripple-carry adder with carry
// in and carry out; one instance resolves one pipeline stage.
module adder_segment #(
   parameter int SEG_WIDTH = 8
) (
   input  logic [SEG_WIDTH-1:0] i_a,
   input  logic [SEG_WIDTH-1:0] i_b,
   input  logic                 i_cin,
   output logic [SEG_WIDTH-1:0] o_sum,
   output logic                 o_cout
);

   logic [SEG_WIDTH:0] w_carry;

   // NOTE: combinational logic uses blocking '=' so each bit sees the carry
   // computed for the bit below it within the same evaluation.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      w_carry    = '0;
      o_sum      = '0;
      w_carry[0] = i_cin;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
         w_carry[i+1]   = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_carry[SEG_WIDTH];
   end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract resolved SEG_WIDTH bits per stage with a
// valid/ready pipeline that collapses bubbles. Optional macro
// PIPELINED_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SEG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   sum
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic                  ovf
`endif
);

   localparam int NUM_SEG_RAW = calc_num_seg(DATA_WIDTH, SEG_WIDTH);
   localparam int NUM_SEG     = (NUM_SEG_RAW < 1) ? 1 : NUM_SEG_RAW;

   if (NUM_SEG_RAW < 1) begin : g_bad_cfg
      $error("pipelined_adder: DATA_WIDTH must be a positive multiple of SEG_WIDTH");
   end

   // Per-stage registers. Operands are shifted right as they advance so every
   // stage consumes the low SEG_WIDTH bits; the result fills in place.
   logic [NUM_SEG-1:0]    r_vld;
   logic [NUM_SEG-1:0]    r_op;
   logic [NUM_SEG-1:0]    r_cy;
   logic [DATA_WIDTH-1:0] r_a   [NUM_SEG];
   logic [DATA_WIDTH-1:0] r_b   [NUM_SEG];
   logic [DATA_WIDTH-1:0] r_res [NUM_SEG];

   // Values presented to each stage's load port.
   logic [NUM_SEG-1:0]    w_load;
   logic [NUM_SEG-1:0]    w_src_vld;
   logic [NUM_SEG-1:0]    w_src_op;
   logic [NUM_SEG-1:0]    w_src_cin;
   logic [NUM_SEG-1:0]    w_seg_cout;
   logic [DATA_WIDTH-1:0] w_src_a     [NUM_SEG];
   logic [DATA_WIDTH-1:0] w_src_b     [NUM_SEG];
   logic [DATA_WIDTH-1:0] w_src_res   [NUM_SEG];
   logic [DATA_WIDTH-1:0] w_nxt_res   [NUM_SEG];
   logic [SEG_WIDTH-1:0]  w_seg_sum   [NUM_SEG];

   op_e w_op;
   assign w_op = op_e'(op);

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign w_src_vld[k] = in_valid;
         assign w_src_op[k]  = op;
         assign w_src_cin[k] = (w_op == OP_SUB);
         assign w_src_a[k]   = a;
         assign w_src_b[k]   = (w_op == OP_SUB) ? ~b : b;
         assign w_src_res[k] = '0;
      end else begin : g_next
         assign w_src_vld[k] = r_vld[k-1];
         assign w_src_op[k]  = r_op[k-1];
         assign w_src_cin[k] = r_cy[k-1];
         assign w_src_a[k]   = r_a[k-1];
         assign w_src_b[k]   = r_b[k-1];
         assign w_src_res[k] = r_res[k-1];
      end

      adder_segment #(
         .SEG_WIDTH (SEG_WIDTH)
      ) u_seg (
         .i_a    (w_src_a[k][SEG_WIDTH-1:0]),
         .i_b    (w_src_b[k][SEG_WIDTH-1:0]),
         .i_cin  (w_src_cin[k]),
         .o_sum  (w_seg_sum[k]),
         .o_cout (w_seg_cout[k])
      );

      // Slice k of the incoming result is still zero, so OR-ing places it.
      assign w_nxt_res[k] = w_src_res[k] | (DATA_WIDTH'(w_seg_sum[k]) << (k * SEG_WIDTH));
   end

   // A stage may load when it is empty or its successor is loading; an empty
   // stage anywhere downstream therefore lets the whole upstream advance.
   always_comb begin
      w_load            = '0;
      w_load[NUM_SEG-1] = !r_vld[NUM_SEG-1] || out_ready;
      for (int k = NUM_SEG - 2; k >= 0; k--) begin
         w_load[k] = !r_vld[k] || w_load[k+1];
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every stage samples its
   // predecessor's value from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_op  <= '0;
         r_cy  <= '0;
         // NOTE: the stage arrays are ordinary flops, not RAM, so they are
         // cleared explicitly; this keeps sum at zero during reset.
         for (int k = 0; k < NUM_SEG; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_res[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_SEG; k++) begin
            if (w_load[k]) begin
               r_vld[k] <= w_src_vld[k];
               r_op[k]  <= w_src_op[k];
               r_cy[k]  <= w_seg_cout[k];
               r_a[k]   <= w_src_a[k] >> SEG_WIDTH;
               r_b[k]   <= w_src_b[k] >> SEG_WIDTH;
               r_res[k] <= w_nxt_res[k];
            end
         end
      end
   end

   // The op bit and the final stage's drained operand registers have no
   // consumer; fold them into a sink.
   logic w_unused;
   assign w_unused = ^{r_op, r_a[NUM_SEG-1], r_b[NUM_SEG-1]};

   assign in_ready  = w_load[0];
   assign out_valid = r_vld[NUM_SEG-1];
   assign sum       = {r_cy[NUM_SEG-1], r_res[NUM_SEG-1]};

`ifdef PIPELINED_ADDER_OVF_EN
   // Signed overflow: operands (b already inverted for subtract) share a sign
   // that differs from the result's sign.
   logic r_ovf;
   logic w_ovf_nxt;

   assign w_ovf_nxt = (w_src_a[NUM_SEG-1][SEG_WIDTH-1] == w_src_b[NUM_SEG-1][SEG_WIDTH-1]) &&
                      (w_seg_sum[NUM_SEG-1][SEG_WIDTH-1] != w_src_a[NUM_SEG-1][SEG_WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_load[NUM_SEG-1]) begin
         r_ovf <= w_ovf_nxt;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (32-bit, 8-bit segments): directed
// vectors with literal expectations plus a queue model checked every cycle.
module tb_pipelined_adder;

   localparam int DW   = 32;
   localparam int SW   = 8;
   localparam int NSEG = DW / SW;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [DW-1:0] a         = '0;
   logic [DW-1:0] b         = '0;
   logic          op        = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW:0]   sum;
`ifdef PIPELINED_ADDER_OVF_EN
   logic          ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipelined_adder #(
      .DATA_WIDTH (DW),
      .SEG_WIDTH  (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic: unsigned 33-bit add, subtract biased by 2^32 so the
   // top bit reads as "no borrow"; overflow from true signed arithmetic.
   function automatic logic [DW:0] model_sum(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                             input logic o);
      if (o) return 33'h1_0000_0000 + {1'b0, x} - {1'b0, y};
      return {1'b0, x} + {1'b0, y};
   endfunction

   function automatic logic model_ovf(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                      input logic o);
      longint sx, sy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = o ? (sx - sy) : (sx + sy);
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   typedef struct {
      logic [DW:0] sum;
      logic        ovf;
   } exp_t;

   exp_t        q[$];
   exp_t        e_head;
   int          n_out      = 0;
   bit          saw_full   = 1'b0;
   bit          prev_stall = 1'b0;
   logic [DW:0] prev_sum   = '0;

   // Compare process: outputs and in_ready are stable mid-cycle; transfers
   // seen here complete at the following rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", {63'b0, in_ready}, {63'b0, (out_ready || (q.size() < NSEG))});
         if (!in_ready) saw_full = 1'b1;
         if (prev_stall) begin
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_sum", {31'b0, sum}, {31'b0, prev_sum});
         end
         prev_stall = out_valid && !out_ready;
         prev_sum   = sum;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
               e_head = q.pop_front();
               check("result_sum", {31'b0, sum}, {31'b0, e_head.sum});
`ifdef PIPELINED_ADDER_OVF_EN
               check("result_ovf", {63'b0, ovf}, {63'b0, e_head.ovf});
`endif
               n_out++;
            end
         end
         if (in_valid && in_ready) q.push_back('{model_sum(a, b, op), model_ovf(a, b, op)});
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

   // Presents one operand set, holding it until accepted. Called just after
   // a rising edge; returns just after the transfer edge.
   task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic to);
      int  guard;
      bit  accepted;
      guard    = 0;
      a        = ta;
      b        = tb;
      op       = to;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk);
         #1;
         if (accepted) break;
         guard++;
         if (guard > 100) begin
            check("send_timeout", {63'b0, in_ready}, 64'd1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Single transaction into an idle pipe: checks latency and literal result.
   task automatic timed_op(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                           input logic to, input logic [DW:0] exp_sum, input logic exp_ovf);
      int lat;
      a        = ta;
      b        = tb;
      op       = to;
      in_valid = 1'b1;
      @(negedge clk);
      check({name, "_in_ready"}, {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      forever begin
         @(negedge clk);
         if (out_valid || lat >= 16) break;
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'(NSEG));
      check({name, "_sum"}, {31'b0, sum}, {31'b0, exp_sum});
`ifdef PIPELINED_ADDER_OVF_EN
      check({name, "_ovf"}, {63'b0, ovf}, {63'b0, exp_ovf});
`else
      if (exp_ovf === 1'bx) check({name, "_ovf_arg"}, 64'd0, 64'd1);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (q.size() != 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      #1;
      check("drain", 64'(q.size()), 64'd0);
   endtask

   logic [DW-1:0] va [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
                             32'h0000_00FF, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0F0F_F0F0};
   logic [DW-1:0] vb [8] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h8765_4321,
                             32'hFFFF_FF01, 32'hCAFE_F00D, 32'h7FFF_FFFF, 32'hF0F0_0F0F};
   bit            vo [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int n0;

      #1;
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check("reset_sum", {31'b0, sum}, 64'd0);
`ifdef PIPELINED_ADDER_OVF_EN
      check("reset_ovf", {63'b0, ovf}, 64'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      timed_op("add_carry_out", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0);
      timed_op("sub_borrow",    32'h0000_0005, 32'h0000_0007, 1'b1, 33'h0_FFFF_FFFE, 1'b0);
      timed_op("sub_no_borrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 33'h1_0000_0002, 1'b0);
      timed_op("add_segments",  32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 33'h0_2143_6587, 1'b0);
      timed_op("add_seg_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 1'b0);
      timed_op("sub_zero",      32'h0000_0000, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b0);
      timed_op("ovf_add_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1);
      timed_op("ovf_sub_neg",   32'h8000_0000, 32'h0000_0001, 1'b1, 33'h1_7FFF_FFFF, 1'b1);
      timed_op("no_ovf_small",  32'h0000_0003, 32'h0000_0004, 1'b0, 33'h0_0000_0007, 1'b0);

      // Back-to-back stream with a six-cycle consumer stall in the middle.
      saw_full = 1'b0;
      n0       = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) send(va[i], vb[i], vo[i]);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check("stall_in_ready_low", {63'b0, saw_full}, 64'd1);
      check("stream_count", 64'(n_out - n0), 64'd8);

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) send(va[i], vb[i], vo[i]);
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
      check("midreset_in_ready", {63'b0, in_ready}, 64'd1);
      check("midreset_sum", {31'b0, sum}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n0    = n_out;
      repeat (10) @(posedge clk);
      #1;
      check("flushed_no_result", 64'(n_out - n0), 64'd0);
      check("flushed_out_valid", {63'b0, out_valid}, 64'd0);
      timed_op("post_reset", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 33'h0_FFFF_FFFF, 1'b0);

      wait_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
